// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter slice.
// Covers the next-PC source selector and the default width and increment.
package pc_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_INC   = 1;

   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_RET,
      SEL_CALL,
      SEL_JUMP,
      SEL_BRANCH,
      SEL_INC
   } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack used by pc_unit for call/return.
// When the stack is full, a push overwrites the oldest entry and the count saturates.
module pc_ras import pc_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [CNT_W-1:0] count;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign top       = mem[ptr - PTR_W'(1)];
   assign overflow  = push & full;
   assign underflow = pop & empty;

   // ptr is the next free slot; once it wraps, that slot holds the oldest entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr   <= '0;
         count <= '0;
      end else if (pop) begin
         if (!empty) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
         end
      end else if (push) begin
         ptr <= ptr + PTR_W'(1);
         if (!full)
            count <= count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push && !pop)
         mem[ptr] <= push_data;
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter with stall, branch, jump and call/return.
// The return-address stack lives in pc_ras.
module pc_unit import pc_pkg::*; #(
   parameter int               WIDTH        = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               INC          = DEFAULT_INC,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             branch,
   input  logic             alu_zero,
   input  logic [WIDTH-1:0] address,
   input  logic             jump,
   input  logic             call,
   input  logic             ret,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] out,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_err
);

   pc_sel_e          sel;
   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] next_pc;
   logic [WIDTH-1:0] ras_top;
   logic             push;
   logic             pop;
   logic             overflow;
   logic             underflow;

   assign seq_pc = out + WIDTH'(INC);
   assign push   = (sel == SEL_CALL);
   assign pop    = (sel == SEL_RET);

   // ret outranks call, so a simultaneous call never pushes.
   always_comb begin
      sel = SEL_INC;
      if (stall)
         sel = SEL_HOLD;
      else if (ret)
         sel = SEL_RET;
      else if (call)
         sel = SEL_CALL;
      else if (jump)
         sel = SEL_JUMP;
      else if (branch && alu_zero)
         sel = SEL_BRANCH;
   end

   // The offset is only added on a taken branch, so an X offset is never used.
   always_comb begin
      next_pc = seq_pc;
      case (sel)
         SEL_HOLD:   next_pc = out;
         SEL_RET:    next_pc = ras_empty ? seq_pc : ras_top;
         SEL_CALL:   next_pc = target;
         SEL_JUMP:   next_pc = target;
         SEL_BRANCH: next_pc = seq_pc + address;
         default:    next_pc = seq_pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out     <= RESET_VECTOR;
         ras_err <= 1'b0;
      end else begin
         out <= next_pc;
         if (overflow || underflow)
            ras_err <= 1'b1;
      end
   end

   pc_ras #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (seq_pc),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .overflow  (overflow),
      .underflow (underflow)
   );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, hand-written corner sequences,
// then random traffic compared against a queue-based reference model.
module tb_pc_unit;

   localparam int DEPTH = 4;

   typedef struct {
      logic        rst_n, stall, branch, alu_zero, jump, call, ret;
      logic [31:0] address, target, exp_out;
      logic        exp_empty, exp_full, exp_err;
   } vec_t;

   logic        clk;
   logic        rst_n, stall, branch, alu_zero, jump, call, ret;
   logic [31:0] address, target, out;
   logic        ras_empty, ras_full, ras_err;

   int assertions = 0;
   int failures   = 0;
   int step       = 0;

   vec_t vecs[$];

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   logic        m_err;

   pc_unit #(
      .WIDTH        (32),
      .RESET_VECTOR (32'd0),
      .INC          (1),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .branch    (branch),
      .alu_zero  (alu_zero),
      .address   (address),
      .jump      (jump),
      .call      (call),
      .ret       (ret),
      .target    (target),
      .out       (out),
      .ras_empty (ras_empty),
      .ras_full  (ras_full),
      .ras_err   (ras_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(logic r, logic s, logic b, logic z, logic [31:0] a,
                               logic j, logic c, logic rt, logic [31:0] t,
                               logic [31:0] eo, logic ee, logic ef, logic er);
      vec_t v;
      v.rst_n = r;  v.stall = s;  v.branch = b;  v.alu_zero = z;  v.address = a;
      v.jump  = j;  v.call  = c;  v.ret    = rt; v.target   = t;
      v.exp_out = eo; v.exp_empty = ee; v.exp_full = ef; v.exp_err = er;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst_n = v.rst_n; stall = v.stall; branch = v.branch; alu_zero = v.alu_zero;
      address = v.address; jump = v.jump; call = v.call; ret = v.ret; target = v.target;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
      end
   endtask

   task automatic runVec(input vec_t v);
      applyStimulus(v);
      checkOutput("out", out, v.exp_out);
      checkOutput("ras_empty", {31'd0, ras_empty}, {31'd0, v.exp_empty});
      checkOutput("ras_full", {31'd0, ras_full}, {31'd0, v.exp_full});
      checkOutput("ras_err", {31'd0, ras_err}, {31'd0, v.exp_err});
      step++;
   endtask

   // Specification-level model: PC as a number, RAS as a bounded queue.
   task automatic modelStep(input vec_t v);
      if (!v.rst_n) begin
         m_pc = 32'd0;
         m_ras.delete();
         m_err = 1'b0;
      end else if (v.stall) begin
         m_pc = m_pc;
      end else if (v.ret) begin
         if (m_ras.size() > 0) begin
            m_pc = m_ras.pop_back();
         end else begin
            m_pc  = m_pc + 32'd1;
            m_err = 1'b1;
         end
      end else if (v.call) begin
         if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_err = 1'b1;
         end
         m_ras.push_back(m_pc + 32'd1);
         m_pc = v.target;
      end else if (v.jump) begin
         m_pc = v.target;
      end else if (v.branch && v.alu_zero) begin
         m_pc = m_pc + 32'd1 + v.address;
      end else begin
         m_pc = m_pc + 32'd1;
      end
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0; stall = 1'b0; branch = 1'b0; alu_zero = 1'b0;
      address = '0; jump = 1'b0; call = 1'b0; ret = 1'b0; target = '0;

      //        rst s  b  z  address       j  c  rt target         out           e  f  err
      vecs.push_back(mk(0, 0, 0, 0, 32'd0,        0, 0, 0, 32'd0,        32'd0,        1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 0, 0, 32'd0,        32'd1,        1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 0, 0, 32'd0,        32'd2,        1, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 32'hx,        0, 0, 0, 32'd0,        32'd3,        1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 32'hx,        0, 0, 0, 32'd0,        32'd4,        1, 0, 0));
      vecs.push_back(mk(1, 0, 1, 1, 32'd10,       0, 0, 0, 32'd0,        32'd15,       1, 0, 0));
      vecs.push_back(mk(1, 0, 1, 1, 32'hFFFFFFFA, 0, 0, 0, 32'd0,        32'd10,       1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 1, 0, 32'd100,      32'd100,      0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 1, 0, 32'd200,      32'd200,      0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 0, 1, 32'd0,        32'd101,      0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 0, 1, 32'd0,        32'd11,       1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 1, 0, 32'd300,      32'd300,      0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 1, 1, 32'd500,      32'd12,       1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 1, 0, 32'd1000,     32'd1000,     0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 1, 0, 32'd2000,     32'd2000,     0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 1, 0, 32'd3000,     32'd3000,     0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 1, 0, 32'd4000,     32'd4000,     0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 1, 0, 32'd5000,     32'd5000,     0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 0, 1, 32'd0,        32'd4001,     0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 0, 1, 32'd0,        32'd3001,     0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 0, 1, 32'd0,        32'd2001,     0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 0, 1, 32'd0,        32'd1001,     1, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 0, 1, 32'd0,        32'd1002,     1, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 32'd0,        0, 0, 0, 32'd0,        32'd0,        1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 32'd0,        0, 0, 0, 32'd0,        32'd0,        1, 0, 0));

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++)
         runVec(vecs[i]);

      // stall freezes the PC and the RAS even with jump/call/ret asserted
      runVec(mk(1, 0, 0, 0, 32'd0, 1, 0, 0, 32'd50,  32'd50, 1, 0, 0));
      for (int i = 0; i < 3; i++)
         runVec(mk(1, 1, 0, 0, 32'd0, 1, 0, 0, 32'd999, 32'd50, 1, 0, 0));
      runVec(mk(1, 1, 0, 0, 32'd0, 0, 1, 0, 32'd777, 32'd50, 1, 0, 0));
      runVec(mk(1, 0, 0, 0, 32'd0, 0, 0, 0, 32'd0,   32'd51, 1, 0, 0));
      runVec(mk(1, 0, 0, 0, 32'd0, 0, 1, 0, 32'd80,  32'd80, 0, 0, 0));
      runVec(mk(1, 1, 0, 0, 32'd0, 0, 0, 1, 32'd0,   32'd80, 0, 0, 0));
      runVec(mk(1, 0, 0, 0, 32'd0, 0, 0, 1, 32'd0,   32'd52, 1, 0, 0));

      // reset in the middle of a call chain drops every stacked address
      runVec(mk(1, 0, 0, 0, 32'd0, 0, 1, 0, 32'd10,  32'd10, 0, 0, 0));
      runVec(mk(1, 0, 0, 0, 32'd0, 0, 1, 0, 32'd20,  32'd20, 0, 0, 0));
      runVec(mk(0, 0, 0, 0, 32'd0, 0, 1, 0, 32'd30,  32'd0,  1, 0, 0));
      runVec(mk(1, 0, 0, 0, 32'd0, 0, 0, 1, 32'd0,   32'd1,  1, 0, 1));

      // random traffic against the reference model, starting from reset
      for (int i = 0; i < 400; i++) begin
         v = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
         v.rst_n    = (i == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
         v.stall    = ($urandom_range(0, 7) == 0);
         v.ret      = ($urandom_range(0, 4) == 0);
         v.call     = ($urandom_range(0, 3) == 0);
         v.jump     = ($urandom_range(0, 7) == 0);
         v.branch   = ($urandom_range(0, 2) == 0);
         v.alu_zero = 1'($urandom_range(0, 1));
         v.address  = $urandom;
         v.target   = $urandom;
         modelStep(v);
         v.exp_out   = m_pc;
         v.exp_empty = (m_ras.size() == 0);
         v.exp_full  = (m_ras.size() == DEPTH);
         v.exp_err   = m_err;
         runVec(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
